// File: rtl/avl_mem_responder.sv
// Avalon-MM memory slave: fixed wait-request count per transfer, byte-enable
// writes, fixed-latency pipelined reads and sticky error flags.
module avl_mem_responder #(
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 32,
    parameter int MEM_AW   = 10,
    parameter int WAIT_CYC = 1,
    parameter int RD_LAT   = 2
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic [ADDR_W-1:0]   avl_addr,
    input  logic                avl_read,
    input  logic                avl_write,
    input  logic [DATA_W-1:0]   avl_wData,
    input  logic [DATA_W/8-1:0] avl_be,
    output logic                avl_wait,
    output logic [DATA_W-1:0]   avl_rData,
    output logic                avl_rData_valid,
    output logic [1:0]          err_flags
);
    localparam int          BE_W     = DATA_W / 8;
    localparam int          DEPTH    = 1 << MEM_AW;
    localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYC);
    localparam logic [31:0] BAD_WORD = 32'hDEAD_BEEF;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [3:0]        wcnt_q, wcnt_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [DATA_W-1:0] dat_q [RD_LAT];
    logic [DATA_W-1:0] dat_d [RD_LAT];
    logic [1:0]        err_q, err_d;

    logic              request, wait_req, accept, in_range, wr_acc, rd_acc;
    logic [MEM_AW-1:0] idx;
    logic [DATA_W-1:0] rd_word, wr_word;

    always_comb begin
        request  = avl_read | avl_write;
        wait_req = request && (wcnt_q != WAIT_LIM);
        accept   = iRST_n && request && !wait_req;
        in_range = (avl_addr >> MEM_AW) == '0;
        idx      = avl_addr[MEM_AW-1:0];
        wr_acc   = accept && avl_write && in_range;
        // A combined read+write is treated as a write only
        rd_acc   = accept && avl_read && !avl_write;
        rd_word  = in_range ? mem_q[idx] : DATA_W'(BAD_WORD);

        wr_word = mem_q[idx];
        for (int b = 0; b < BE_W; b++) begin
            if (avl_be[b]) begin
                wr_word[b*8 +: 8] = avl_wData[b*8 +: 8];
            end
        end

        wcnt_d = (request && wait_req) ? wcnt_q + 4'd1 : 4'd0;
        err_d  = err_q | {accept && avl_read && avl_write, accept && !in_range};

        vld_d[0] = rd_acc;
        dat_d[0] = rd_word;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = dat_q[k-1];
        end
        // Output stage keeps the last returned word between responses
        if (!vld_d[RD_LAT-1]) begin
            dat_d[RD_LAT-1] = dat_q[RD_LAT-1];
        end

        avl_wait        = !iRST_n || wait_req;
        avl_rData       = dat_q[RD_LAT-1];
        avl_rData_valid = vld_q[RD_LAT-1];
        err_flags       = err_q;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wcnt_q <= '0;
            vld_q  <= '0;
            err_q  <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            wcnt_q <= wcnt_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            for (int k = 0; k < RD_LAT; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    // Storage survives reset by design
    always_ff @(posedge iCLK) begin
        if (wr_acc) begin
            mem_q[idx] <= wr_word;
        end
    end

endmodule

// File: doc/avl_mem_responder.md
AVL_MEM_RESPONDER -- requirements
Module: avl_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning Avalon address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width (multiple of 8).
REQ-003 SHALL have parameter MEM_AW, default 10, meaning log2 of storage depth in words.
REQ-004 SHALL have parameter WAIT_CYC, default 1, meaning wait-request cycles per transfer (0..15).
REQ-005 SHALL have parameter RD_LAT, default 2, meaning cycles from read acceptance to avl_rData_valid (1..8).
REQ-006 SHALL have one clock and an asynchronous, active-low reset: iCLK input 1 system clock; iRST_n input 1 reset, active low.
REQ-007 SHALL have port avl_addr, input, ADDR_W bits, word address.
REQ-008 SHALL have port avl_read, input, 1 bit, read request.
REQ-009 SHALL have port avl_write, input, 1 bit, write request.
REQ-010 SHALL have port avl_wData, input, DATA_W bits, write data.
REQ-011 SHALL have port avl_be, input, DATA_W/8 bits, byte enables for writes.
REQ-012 SHALL have port avl_wait, output, 1 bit, wait-request.
REQ-013 SHALL have port avl_rData, output, DATA_W bits, read data.
REQ-014 SHALL have port avl_rData_valid, output, 1 bit, read data valid.
REQ-015 SHALL have port err_flags, output, 2 bits: bit0 out-of-range access, bit1 simultaneous read+write; both sticky.

Function
REQ-016 SHALL contain DATA_W x 2^MEM_AW storage, indexed by avl_addr[MEM_AW-1:0].
REQ-017 SHALL keep 4-bit wait counter wcnt; request = avl_read|avl_write.
REQ-018 SHALL drive avl_wait = request && (wcnt != WAIT_CYC), combinationally; avl_wait=0 when no request.
REQ-019 SHALL increment wcnt each cycle request && avl_wait; clear wcnt on acceptance (request && !avl_wait) or when request=0.
REQ-020 SHALL accept at most one transfer per cycle; with WAIT_CYC=0, accept in first cycle of request, giving back-to-back throughput of 1/cycle.
REQ-021 Accepted write SHALL update only bytes whose avl_be bit is 1, at the rising edge ending the accept cycle.
REQ-022 Accepted read SHALL sample storage at the accept edge and present avl_rData with avl_rData_valid=1 for exactly one cycle, RD_LAT cycles after the accept edge, via a RD_LAT-deep valid/data shift pipeline.
REQ-023 Read responses SHALL return in acceptance order; up to RD_LAT reads outstanding; no stall for read pipeline occupancy.
REQ-024 Read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-025 avl_rData SHALL hold its last valid value when avl_rData_valid=0.
REQ-026 If avl_addr[ADDR_W-1:MEM_AW] != 0 at acceptance: write discarded, read returns 32'hDEADBEEF (low DATA_W bits) at normal latency, err_flags[0] set.
REQ-027 If avl_read and avl_write both 1 at acceptance: write performed, read ignored (no response), err_flags[1] set.
REQ-028 Changes to avl_addr/avl_wData while avl_wait=1 SHALL NOT restart wcnt; values at the accept cycle are used.

Reset
REQ-029 While iRST_n=0: avl_rData=0, avl_rData_valid=0, err_flags=0, wcnt=0, read pipeline cleared, avl_wait=1.
REQ-030 Reset asserted with reads outstanding SHALL discard them; no avl_rData_valid pulse after release for pre-reset reads.
REQ-031 Storage contents SHALL NOT be cleared by reset.
REQ-032 First request after release SHALL see full WAIT_CYC wait cycles.

Verification
REQ-033 Defaults; write addr 5 data 32'hA5A5_1234 be 4'hF -> avl_wait high 1 cycle then accepted; read addr 5 -> avl_rData_valid pulse 2 cycles after accept, data 32'hA5A5_1234.
REQ-034 WAIT_CYC=0, RD_LAT=3; reads addr 0,1,2,3 back-to-back -> avl_wait stays 0, four consecutive valid pulses, in order, starting 3 cycles after first accept.
REQ-035 Write 32'hFFFF_FFFF to addr 7, then write 32'h0000_0000 be 4'b0101 -> read returns 32'hFF00_FF00.
REQ-036 Read addr 28'h000_0400 (MEM_AW=10) -> data 32'hDEADBEEF, err_flags=2'b01; read+write same cycle addr 3 data 9 -> addr 3 holds 9, no read pulse, err_flags=2'b11.
REQ-037 Two reads accepted, iRST_n pulsed low before first valid -> no avl_rData_valid for 10 cycles after release; err_flags=0; prior stored data still readable.
